// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the integer register file write port between the
// execute (req0) and load (req1) writeback paths, with a registered write command.
module regfile_wb_arbiter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [WIDTH-1:0]      req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [WIDTH-1:0]      req1_data,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  wr_src,
    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    typedef struct packed {
        logic                  en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      data;
        logic                  src;
    } wr_cmd_t;

    localparam int unsigned CmdW = $bits(wr_cmd_t);

    wr_cmd_t                wr_q, wr_d;
    logic                   last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   both_valid;
    logic                   hs0, hs1;

    assign both_valid = req0_valid && req1_valid;

    // Grant: single requester wins outright; on contention the one not granted last wins.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!flush) begin
            if (both_valid) begin
                req0_ready = last_grant_q;
                req1_ready = !last_grant_q;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
    end

    assign hs0 = req0_valid && req0_ready;
    assign hs1 = req1_valid && req1_ready;

    // Next write command; address/data/source hold when nothing is accepted.
    always_comb begin
        wr_d         = wr_q;
        wr_d.en      = 1'b0;
        last_grant_d = last_grant_q;
        if (hs0) begin
            wr_d.en      = |req0_addr;
            wr_d.addr    = req0_addr;
            wr_d.data    = req0_data;
            wr_d.src     = 1'b0;
            last_grant_d = 1'b0;
        end else if (hs1) begin
            wr_d.en      = |req1_addr;
            wr_d.addr    = req1_addr;
            wr_d.data    = req1_data;
            wr_d.src     = 1'b1;
            last_grant_d = 1'b1;
        end
    end

    // Contention counter saturates at all-ones; flush cycles still count.
    always_comb begin
        cnt_d = cnt_q;
        if (both_valid && (cnt_q != {CNT_WIDTH{1'b1}})) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q         <= CmdW'(0);
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
        end else begin
            wr_q         <= wr_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign wr_en        = wr_q.en;
    assign wr_addr      = wr_q.addr;
    assign wr_data      = wr_q.data;
    assign wr_src       = wr_q.src;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed vector table, saturation,
// async reset, and randomized traffic against a transaction-level reference model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        v0, v1, r0, r1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        wr_en, wr_src;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [15:0] cnt;

    logic        sat_valid;
    logic        s_r0, s_r1, s_en, s_src;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic [3:0]  s_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(v0), .req0_ready(r0), .req0_addr(a0), .req0_data(d0),
        .req1_valid(v1), .req1_ready(r1), .req1_addr(a1), .req1_data(d1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src),
        .conflict_cnt(cnt)
    );

    regfile_wb_arbiter #(.CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .flush(1'b0),
        .req0_valid(sat_valid), .req0_ready(s_r0), .req0_addr(5'd3), .req0_data(32'h1),
        .req1_valid(sat_valid), .req1_ready(s_r1), .req1_addr(5'd4), .req1_data(32'h2),
        .wr_en(s_en), .wr_addr(s_addr), .wr_data(s_data), .wr_src(s_src),
        .conflict_cnt(s_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic iv0, input logic [4:0] ia0, input logic [31:0] id0,
                         input logic iv1, input logic [4:0] ia1, input logic [31:0] id1);
        flush = fl; v0 = iv0; a0 = ia0; d0 = id0; v1 = iv1; a1 = ia1; d1 = id1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        logic        fl;
        logic        v0; logic [4:0] a0; logic [31:0] d0;
        logic        v1; logic [4:0] a1; logic [31:0] d1;
        logic        r0; logic r1;
        logic        en; logic [4:0] addr; logic [31:0] data; logic src;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[10];

    // Reference model state: what the write port and counter should show.
    logic        m_last;
    logic        m_en, m_src;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int unsigned m_cnt;
    bit          p0, p1;
    logic [4:0]  pa0, pa1;
    logic [31:0] pd0, pd1;
    int          winner;

    initial begin
        sat_valid = 1'b0;
        do_reset();

        // Reset state.
        #3;
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_wr_src", 64'(wr_src), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_ready", 64'({r0, r1}), 64'd0);

        // Saturation of a 4-bit counter.
        @(posedge clk); #1 sat_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("sat_cnt10", 64'(s_cnt), 64'd10);
        repeat (10) @(posedge clk);
        #1 chk("sat_cnt20", 64'(s_cnt), 64'd15);
        sat_valid = 1'b0;

        // Directed sequence; the main DUT has been idle so last grant is still req1.
        tbl[0] = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0,  1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 16'd0};
        tbl[1] = '{1'b0, 1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h22,  1'b0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 16'd0};
        tbl[2] = '{1'b0, 1'b1, 5'd1, 32'h11,       1'b1, 5'd2, 32'h23,  1'b1, 1'b0, 1'b1, 5'd2, 32'h22,       1'b1, 16'd1};
        tbl[3] = '{1'b0, 1'b1, 5'd1, 32'h12,       1'b1, 5'd2, 32'h23,  1'b0, 1'b1, 1'b1, 5'd1, 32'h11,       1'b0, 16'd2};
        tbl[4] = '{1'b0, 1'b1, 5'd1, 32'h12,       1'b1, 5'd3, 32'h24,  1'b1, 1'b0, 1'b1, 5'd2, 32'h23,       1'b1, 16'd3};
        tbl[5] = '{1'b0, 1'b0, 5'd0, 32'd0,        1'b1, 5'd0, 32'h1234,1'b0, 1'b1, 1'b1, 5'd1, 32'h12,       1'b0, 16'd4};
        tbl[6] = '{1'b1, 1'b1, 5'd7, 32'h77,       1'b1, 5'd8, 32'h88,  1'b0, 1'b0, 1'b0, 5'd0, 32'h1234,     1'b1, 16'd4};
        tbl[7] = '{1'b0, 1'b1, 5'd7, 32'h77,       1'b1, 5'd8, 32'h88,  1'b1, 1'b0, 1'b0, 5'd0, 32'h1234,     1'b1, 16'd5};
        tbl[8] = '{1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,   1'b0, 1'b0, 1'b1, 5'd7, 32'h77,       1'b0, 16'd6};
        tbl[9] = '{1'b0, 1'b0, 5'd0, 32'd0,        1'b0, 5'd0, 32'd0,   1'b0, 1'b0, 1'b0, 5'd7, 32'h77,       1'b0, 16'd6};

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].fl, tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1);
            #3;
            chk($sformatf("v%0d_r0", i), 64'(r0), 64'(tbl[i].r0));
            chk($sformatf("v%0d_r1", i), 64'(r1), 64'(tbl[i].r1));
            chk($sformatf("v%0d_en", i), 64'(wr_en), 64'(tbl[i].en));
            chk($sformatf("v%0d_addr", i), 64'(wr_addr), 64'(tbl[i].addr));
            chk($sformatf("v%0d_data", i), 64'(wr_data), 64'(tbl[i].data));
            chk($sformatf("v%0d_src", i), 64'(wr_src), 64'(tbl[i].src));
            chk($sformatf("v%0d_cnt", i), 64'(cnt), 64'(tbl[i].cnt));
            @(posedge clk); #1;
        end

        // Async reset between edges while a write is on the port.
        drive(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        chk("ar_pre_en", 64'(wr_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_en", 64'(wr_en), 64'd0);
        chk("ar_addr", 64'(wr_addr), 64'd0);
        chk("ar_data", 64'(wr_data), 64'd0);
        chk("ar_cnt", 64'(cnt), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        drive(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
        #3;
        chk("ar_first_r0", 64'(r0), 64'd1);
        chk("ar_first_r1", 64'(r1), 64'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #3;
        chk("ar_first_src", 64'(wr_src), 64'd0);
        chk("ar_first_addr", 64'(wr_addr), 64'd4);

        // Randomized traffic against the reference model.
        @(posedge clk);
        do_reset();
        m_last = 1'b1; m_en = 1'b0; m_src = 1'b0; m_addr = '0; m_data = '0; m_cnt = 0;
        p0 = 0; p1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        for (int c = 0; c < 600; c++) begin
            logic fl;
            if (!p0 && ($urandom % 3 != 0)) begin
                p0 = 1; pa0 = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom); pd0 = $urandom;
            end
            if (!p1 && ($urandom % 3 != 0)) begin
                p1 = 1; pa1 = ($urandom % 6 == 0) ? 5'd0 : 5'($urandom); pd1 = $urandom;
            end
            fl = ($urandom % 8 == 0);
            drive(fl, p0, pa0, pd0, p1, pa1, pd1);
            if (fl) winner = -1;
            else if (p0 && p1) winner = m_last ? 0 : 1;
            else if (p0) winner = 0;
            else if (p1) winner = 1;
            else winner = -1;
            #3;
            chk("rnd_r0", 64'(r0), 64'(winner == 0));
            chk("rnd_r1", 64'(r1), 64'(winner == 1));
            chk("rnd_en", 64'(wr_en), 64'(m_en));
            chk("rnd_addr", 64'(wr_addr), 64'(m_addr));
            chk("rnd_data", 64'(wr_data), 64'(m_data));
            chk("rnd_src", 64'(wr_src), 64'(m_src));
            chk("rnd_cnt", 64'(cnt), 64'(m_cnt));
            @(posedge clk);
            if (p0 && p1 && m_cnt < 65535) m_cnt++;
            m_en = 1'b0;
            if (winner == 0) begin
                m_addr = pa0; m_data = pd0; m_src = 1'b0; m_en = (pa0 != 0); m_last = 1'b0; p0 = 0;
            end else if (winner == 1) begin
                m_addr = pa1; m_data = pd1; m_src = 1'b1; m_en = (pa1 != 0); m_last = 1'b1; p1 = 0;
            end
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
